// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control FSM: state codes, ALU/cmd codes,
// datapath select constants and the bundled control-word type.
package multicycle_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0,
                         S_DECODE = 4'd1,
                         S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,
                         S_MEMWB  = 4'd4,
                         S_MEMWR  = 4'd5,
                         S_EXECR  = 4'd6,
                         S_EXECI  = 4'd7,
                         S_ALUWB  = 4'd8,
                         S_BRANCH = 4'd9,
                         S_MCWAIT = 4'd10;

  localparam logic [1:0] ALU_ADD = 2'b00,
                         ALU_SUB = 2'b01,
                         ALU_AND = 2'b10,
                         ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000,
                         CMD_SUB = 4'b0010,
                         CMD_ADD = 4'b0100,
                         CMD_ORR = 4'b1100,
                         CMD_CMP = 4'b1010,
                         CMD_CMN = 4'b1011;

  localparam logic [1:0] OP_DP  = 2'b00,
                         OP_MEM = 2'b01,
                         OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00,
                         RES_DATA      = 2'b01,
                         RES_ALURESULT = 2'b10,
                         RES_MCYCLE    = 2'b11;

  localparam logic [1:0] SRCB_RM   = 2'b00,
                         SRCB_IMM  = 2'b01,
                         SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] res_src;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       start;
    logic       undef;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between multicycle_ctrl (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic        CondEx;
  logic        MemRdy;
  logic        Busy;
  logic        MemReq;
  logic        IRWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUControl;
  logic [1:0]  FlagW;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        Start;
  logic        Undef;
  logic [3:0]  State;

  modport master (
    input  Instr, CondEx, MemRdy, Busy,
    output MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           FlagW, PCWrite, RegWrite, MemWrite, Start, Undef, State
  );

  modport slave (
    output Instr, CondEx, MemRdy, Busy,
    input  MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           FlagW, PCWrite, RegWrite, MemWrite, Start, Undef, State
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational ALU decoder: cmd/S/U -> ALUControl, raw FlagW, NoWrite, IllegalCmd.
module mc_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] cmd_i,
  input  logic       s_i,
  input  logic       u_i,
  input  logic       mem_i,
  output logic [1:0] alu_ctrl_o,
  output logic [1:0] flagw_o,
  output logic       nowrite_o,
  output logic       illegal_o
);
  logic arith;

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    arith      = 1'b0;
    nowrite_o  = 1'b0;
    illegal_o  = 1'b0;
    if (mem_i) begin
      alu_ctrl_o = u_i ? ALU_ADD : ALU_SUB;
    end else begin
      case (cmd_i)
        CMD_ADD: arith = 1'b1;
        CMD_SUB: begin alu_ctrl_o = ALU_SUB; arith = 1'b1; end
        CMD_AND: alu_ctrl_o = ALU_AND;
        CMD_ORR: alu_ctrl_o = ALU_ORR;
        CMD_CMP: begin alu_ctrl_o = ALU_SUB; arith = 1'b1; nowrite_o = 1'b1; end
        CMD_CMN: begin arith = 1'b1; nowrite_o = 1'b1; end
        default: illegal_o = 1'b1;
      endcase
    end
    // Logical ops only update NZ; arithmetic ops update all four flags.
    flagw_o = (s_i && !mem_i && !illegal_o) ? (arith ? 2'b11 : 2'b10) : 2'b00;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with CondEx-gated writes.
// Optional MCycle multiply/divide path is enabled by defining MCYCLE_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE     = S_FETCH,
  parameter bit         DEBUG_STATE_OUT = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  multicycle_ctrl_if.master bus
);
  logic [3:0] state_q, state_d;
  logic       start_q, start_d;
  logic       mc_q, mc_d;
  ctrl_t      ctrl, ctrl_gated;
  logic [1:0] dec_alu, dec_flagw;
  logic       dec_nowrite, dec_illegal;
  logic       is_memadr, rd_is_pc;
  logic       unused_bits;

  assign is_memadr   = (state_q == S_MEMADR);
  assign rd_is_pc    = (bus.Instr[15:12] == 4'hF);
  assign unused_bits = ^{bus.Instr, bus.Busy};

  mc_alu_dec u_alu_dec (
    .cmd_i      (bus.Instr[24:21]),
    .s_i        (bus.Instr[20]),
    .u_i        (bus.Instr[23]),
    .mem_i      (is_memadr),
    .alu_ctrl_o (dec_alu),
    .flagw_o    (dec_flagw),
    .nowrite_o  (dec_nowrite),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RESET_STATE;
      start_q <= 1'b0;
      mc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mc_q    <= mc_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = S_FETCH;
    start_d = 1'b0;
    mc_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.res_src   = RES_ALURESULT;
        state_d        = S_FETCH;
        if (bus.MemRdy) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        case (bus.Instr[27:26])
          OP_DP: begin
            state_d = bus.Instr[25] ? S_EXECI : S_EXECR;
`ifdef MCYCLE_EN
            if (!bus.Instr[25] && bus.Instr[7:4] == 4'b1001) begin
              state_d = S_MCWAIT;
              start_d = 1'b1;
            end
`endif
          end
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: ctrl.undef = 1'b1;
        endcase
      end
      S_EXECR, S_EXECI: begin
        ctrl.alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RM;
        ctrl.alu_ctrl  = dec_alu;
        ctrl.flag_w    = bus.CondEx ? dec_flagw : 2'b00;
        if (dec_illegal)      ctrl.undef = 1'b1;
        else if (!dec_nowrite) state_d   = S_ALUWB;
      end
      S_ALUWB, S_MEMWB: begin
        ctrl.res_src   = (state_q == S_MEMWB) ? RES_DATA : (mc_q ? RES_MCYCLE : RES_ALUOUT);
        ctrl.pc_write  = bus.CondEx & rd_is_pc;
        ctrl.reg_write = bus.CondEx & ~rd_is_pc;
      end
      S_MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = dec_alu;
        state_d        = bus.Instr[20] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        state_d      = bus.MemRdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = bus.CondEx;
        state_d        = bus.MemRdy ? S_FETCH : S_MEMWR;
      end
      S_BRANCH: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.res_src   = RES_ALURESULT;
        ctrl.pc_write  = bus.CondEx;
      end
`ifdef MCYCLE_EN
      S_MCWAIT: begin
        // start_q marks the first MCWAIT cycle, before Busy is meaningful.
        ctrl.start = start_q;
        state_d    = S_MCWAIT;
        if (!bus.Busy && !start_q) begin
          state_d = S_ALUWB;
          mc_d    = 1'b1;
        end
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low for as long as the asynchronous reset is asserted.
  assign ctrl_gated = RESET ? ctrl : '0;

  assign bus.MemReq     = ctrl_gated.mem_req;
  assign bus.IRWrite    = ctrl_gated.ir_write;
  assign bus.AdrSrc     = ctrl_gated.adr_src;
  assign bus.ALUSrcA    = ctrl_gated.alu_src_a;
  assign bus.ALUSrcB    = ctrl_gated.alu_src_b;
  assign bus.ResultSrc  = ctrl_gated.res_src;
  assign bus.ALUControl = ctrl_gated.alu_ctrl;
  assign bus.FlagW      = ctrl_gated.flag_w;
  assign bus.PCWrite    = ctrl_gated.pc_write;
  assign bus.RegWrite   = ctrl_gated.reg_write;
  assign bus.MemWrite   = ctrl_gated.mem_write;
  assign bus.Start      = ctrl_gated.start;
  assign bus.Undef      = ctrl_gated.undef;
  assign bus.State      = (RESET && DEBUG_STATE_OUT) ? state_q : '0;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction trace model predicts every cycle's outputs.
module tb_multicycle_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int unsigned checks = 0;
  int unsigned errors = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.RESET_STATE(4'd0), .DEBUG_STATE_OUT(1'b1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  // Expected output word (top 21 bits) followed by the inputs to drive in that cycle.
  typedef struct packed {
    logic [3:0] st;
    logic       memreq, irw, adrsrc, srca;
    logic [1:0] srcb, ress, aluc, flagw;
    logic       pcw, regw, memw, start, undef;
    logic       mr, bz, irv;
  } exp_t;

  exp_t q[$];

  function automatic logic [20:0] act_vec();
    return {bus.State, bus.MemReq, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ResultSrc, bus.ALUControl, bus.FlagW, bus.PCWrite, bus.RegWrite,
            bus.MemWrite, bus.Start, bus.Undef};
  endfunction

  function automatic exp_t row(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.mr  = 1'b1;
    e.irv = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [3:0] st, input logic [1:0] rs, input logic cx, input logic [3:0] rd);
    exp_t e;
    e = row(st);
    e.ress = rs;
    if (rd == 4'hF) e.pcw = cx;
    else            e.regw = cx;
    q.push_back(e);
  endtask

  // Builds the cycle-by-cycle expectation of one instruction from its fields.
  task automatic build(input logic [31:0] ins, input logic cx, input int fst, input int mst, input int bsy);
    exp_t e;
    logic [1:0] alu;
    logic ar, nw, ill;
    q.delete();
    for (int k = 0; k <= fst; k++) begin
      e = row(4'd0);
      e.irv = 1'b0; e.memreq = 1'b1; e.srca = 1'b1; e.srcb = 2'd2; e.ress = 2'd2;
      e.mr = (k == fst); e.irw = (k == fst); e.pcw = (k == fst);
      q.push_back(e);
    end
    e = row(4'd1);
    e.srca = 1'b1; e.srcb = 2'd2;
    if (ins[27:26] == 2'b11) begin
      e.undef = 1'b1;
      q.push_back(e);
      return;
    end
    q.push_back(e);
    case (ins[27:26])
      2'b00: begin
`ifdef MCYCLE_EN
        if (!ins[25] && ins[7:4] == 4'b1001) begin
          for (int k = 0; k < ((bsy > 0) ? bsy : 1) + 1; k++) begin
            e = row(4'd10);
            e.start = (k == 0);
            e.bz = (k < bsy);
            q.push_back(e);
          end
          push_wb(4'd8, 2'd3, cx, ins[15:12]);
          return;
        end
`endif
        alu = 2'd0; ar = 1'b0; nw = 1'b0; ill = 1'b0;
        case (ins[24:21])
          4'b0100: ar = 1'b1;
          4'b0010: begin alu = 2'd1; ar = 1'b1; end
          4'b0000: alu = 2'd2;
          4'b1100: alu = 2'd3;
          4'b1010: begin alu = 2'd1; ar = 1'b1; nw = 1'b1; end
          4'b1011: begin ar = 1'b1; nw = 1'b1; end
          default: ill = 1'b1;
        endcase
        e = row(ins[25] ? 4'd7 : 4'd6);
        e.srcb = ins[25] ? 2'd1 : 2'd0;
        if (ill) begin
          e.undef = 1'b1;
          q.push_back(e);
          return;
        end
        e.aluc = alu;
        e.flagw = (ins[20] && cx) ? (ar ? 2'd3 : 2'd2) : 2'd0;
        q.push_back(e);
        if (!nw) push_wb(4'd8, 2'd0, cx, ins[15:12]);
      end
      2'b01: begin
        e = row(4'd2);
        e.srcb = 2'd1; e.aluc = ins[23] ? 2'd0 : 2'd1;
        q.push_back(e);
        for (int k = 0; k <= mst; k++) begin
          e = row(ins[20] ? 4'd3 : 4'd5);
          e.memreq = 1'b1; e.adrsrc = 1'b1; e.mr = (k == mst);
          e.memw = ins[20] ? 1'b0 : cx;
          q.push_back(e);
        end
        if (ins[20]) push_wb(4'd4, 2'd1, cx, ins[15:12]);
      end
      default: begin
        e = row(4'd9);
        e.srcb = 2'd1; e.ress = 2'd2; e.pcw = cx;
        q.push_back(e);
      end
    endcase
  endtask

  task automatic run(input string name, input logic [31:0] ins, input logic cx, input int fst,
                     input int mst, input int bsy, input int exp_len, input int exp_undef,
                     input int stop_at);
    int undef_seen;
    undef_seen = 0;
    build(ins, cx, fst, mst, bsy);
    if (stop_at < 0) chk({name, "_len"}, q.size(), exp_len);
    for (int i = 0; i < q.size(); i++) begin
      if (i == stop_at) break;
      bus.Instr  = q[i].irv ? ins : ~ins;
      bus.CondEx = cx;
      bus.MemRdy = q[i].mr;
      bus.Busy   = q[i].bz;
      #2;
      chk($sformatf("%s_c%0d_st%0d", name, i, q[i].st), {11'd0, act_vec()}, {11'd0, q[i][23:3]});
      if (bus.Undef) undef_seen++;
      @(posedge CLK);
      @(negedge CLK);
    end
    if (stop_at < 0) chk({name, "_undef"}, undef_seen, exp_undef);
  endtask

  initial begin
    RESET = 1'b0;
    bus.Instr = '0; bus.CondEx = 1'b1; bus.MemRdy = 1'b1; bus.Busy = 1'b0;
    #2 chk("reset_outs", {11'd0, act_vec()}, 32'd0);
    @(posedge CLK); @(negedge CLK);
    chk("reset_hold", {11'd0, act_vec()}, 32'd0);
    RESET = 1'b1;

    run("add",       32'hE0821003, 1'b1, 0, 0, 0, 4, 0, -1);
    run("subs",      32'hE2500001, 1'b1, 0, 0, 0, 4, 0, -1);
    run("cmp",       32'hE3500000, 1'b1, 0, 0, 0, 3, 0, -1);
    run("ldr_stall", 32'hE5154008, 1'b1, 0, 2, 0, 7, 0, -1);
    run("str_nc",    32'hE5854004, 1'b0, 0, 1, 0, 5, 0, -1);
    run("bne_nc",    32'h1AFFFFFE, 1'b0, 0, 0, 0, 3, 0, -1);
    run("undef_op",  32'hEC000000, 1'b1, 0, 0, 0, 2, 1, -1);
    run("add_pc",    32'hE280F008, 1'b1, 0, 0, 0, 4, 0, -1);
    run("ands",      32'hE0121003, 1'b1, 0, 0, 0, 4, 0, -1);
    run("orrs_nc",   32'hE1911002, 1'b0, 0, 0, 0, 4, 0, -1);
    run("eor_ill",   32'hE0221003, 1'b1, 0, 0, 0, 3, 1, -1);
    run("add_fstall",32'hE0821003, 1'b1, 2, 0, 0, 6, 0, -1);
    run("cmn",       32'hE3700001, 1'b1, 0, 0, 0, 3, 0, -1);
    run("ldr_pc",    32'hE595F000, 1'b1, 0, 0, 0, 5, 0, -1);
`ifdef MCYCLE_EN
    run("mul",       32'hE0010392, 1'b1, 0, 0, 5, 9, 0, -1);
`else
    run("mul_as_and",32'hE0010392, 1'b1, 0, 0, 5, 4, 0, -1);
`endif

    // Reset asserted between edges while the DUT waits in MEMRD.
    run("ldr_rst",   32'hE5154008, 1'b1, 0, 3, 0, 0, 0, 4);
    chk("pre_rst_state", {28'd0, bus.State}, 32'd3);
    bus.MemRdy = 1'b0;
    #3 RESET = 1'b0;
    #1 chk("rst_async", {11'd0, act_vec()}, 32'd0);
    @(posedge CLK);
    #2 chk("rst_held", {11'd0, act_vec()}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    run("add_after_rst", 32'hE0821003, 1'b1, 0, 0, 0, 4, 0, -1);
    #2 chk("end_fetch", {28'd0, bus.State}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle ARM core. It sequences the shared ALU, the unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEM/WB steps, issuing per-state datapath selects and write strobes. It reads instruction fields from the latched IR and qualifies all architectural writes with CondEx from the condition unit. It sits between the IR/condition unit and the multicycle datapath.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); not to be overridden in the core
DEBUG_STATE_OUT, 1, 1 drives State port; 0 ties State to 0

Ports:
CLK  in  1  core clock, rising edge
RESET  in  1  asynchronous, active-low reset
Instr  in  32  latched IR contents; valid from DECODE onward
CondEx  in  1  condition passed for current instruction
MemRdy  in  1  memory port completes the access this cycle
Busy  in  1  MCycle unit busy (used only with MCYCLE_EN)
MemReq  out  1  memory access request
IRWrite  out  1  load IR
AdrSrc  out  1  0=PC, 1=ALUResult
ALUSrcA  out  1  0=Rn, 1=PC
ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=MCycle result
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
FlagW  out  2  [1]=NZ write, [0]=CV write
PCWrite  out  1  PC load
RegWrite  out  1  register file write
MemWrite  out  1  memory write strobe
Start  out  1  one-cycle MCycle start pulse
Undef  out  1  one-cycle pulse on unsupported opcode
State  out  4  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, MCWAIT=10; other codes go to FETCH.
- RESET low: state=FETCH immediately; every output, including State, forced 0 while RESET is low. First FETCH cycle follows RESET release.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. Hold until MemRdy=1. In the MemRdy cycle: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALU ADD (PC+8). Branch on Op=Instr[27:26]:
  - 00 with I=0 -> EXECR; 00 with I=1 -> EXECI.
  - 01 -> MEMADR.
  - 10 -> BRANCH.
  - 11 -> Undef=1 for one cycle, then FETCH.
- EXECR/EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl by cmd=Instr[24:21]: 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01, 1011 (CMN)->00. Any other cmd -> Undef pulse, then FETCH.
  - FlagW when S=Instr[20]=1 and CondEx=1: ADD/SUB/CMP/CMN -> 11; AND/ORR -> 10. Otherwise 00.
  - Next state: CMP/CMN (NoWrite) -> FETCH; else ALUWB.
- ALUWB: ResultSrc=00; RegWrite=CondEx. If Rd=Instr[15:12]=15, PCWrite=CondEx instead of RegWrite. Then FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00 if U=Instr[23]=1 else 01. L=Instr[20]: 1 -> MEMRD, 0 -> MEMWR.
- MEMRD: MemReq=1, AdrSrc=1. Hold until MemRdy, then MEMWB.
- MEMWB: ResultSrc=01; RegWrite=CondEx (PCWrite=CondEx if Rd=15). Then FETCH.
- MEMWR: MemReq=1, AdrSrc=1, MemWrite=CondEx. Hold until MemRdy, then FETCH.
  - If CondEx=0, MEMWR and MEMRD still proceed with MemWrite=0. MEMRD still reads; only the write-back is suppressed.
- BRANCH: ALUSrcA=0 (R15 path), ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Then FETCH.
- Unlisted outputs in each state are 0.
- Latency: DP=4 cycles, CMP=3, LDR=5, STR=4, B=3 (MemRdy=1 throughout). Each MemRdy-low cycle adds 1.
- MemRdy is sampled only in FETCH/MEMRD/MEMWR. Instr is sampled only after DECODE entry.

Optional Feature:
MCYCLE_EN:
- Defined: in DECODE, Op=00, I=0 and Instr[7:4]=1001 -> MCWAIT.
  - Start=1 in the first MCWAIT cycle only.
  - Stay in MCWAIT while Busy=1 or during the Start cycle.
  - Then ALUWB with ResultSrc=11.
- Undefined: Start tied 0, Busy ignored, MCWAIT unreachable; 1001 patterns decode as ordinary data-processing.

Decomposition:
- Package multicycle_ctrl_pkg: state encodings, ALUControl codes, cmd codes, ResultSrc/ALUSrcB select constants.
- Sub-module mc_alu_dec: combinational cmd/S/U -> ALUControl, FlagW, NoWrite, IllegalCmd.
- FSM, state register and write gating stay in multicycle_ctrl.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), MemRdy=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
- SUBS R0,R0,#1 with CondEx=1 -> EXECI FlagW=11, ALUControl=01; CMP R0,#0 -> EXECI then FETCH, no RegWrite.
- LDR R4,[R5,#-8] (U=0), MemRdy held low 2 cycles in MEMRD -> ALUControl=01 in MEMADR, MEMRD lasts 3 cycles, RegWrite in MEMWB; total 7 cycles.
- STR with CondEx=0 -> MEMWR visited, MemWrite=0 throughout; BNE with CondEx=0 -> PCWrite=0 in BRANCH.
- Op=11 instruction -> Undef high exactly 1 cycle, return to FETCH; RESET driven low mid-MEMRD -> all outputs 0 at once, FETCH after release.
- MCYCLE_EN, MUL with Busy high 5 cycles -> Start 1-cycle pulse, MCWAIT held, ALUWB with ResultSrc=11.
